// File: rtl/trivium_stream_decrypt.sv
// Trivium receive path: pairs each ciphertext byte with one popped keystream
// byte, XORs them, and queues the recovered plaintext in a show-ahead FIFO.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_DISCARD | dropping leading keystream bytes to align with the far end
// ST_IDLE    | waiting for a ciphertext byte (only when a FIFO slot is free)
// ST_WAIT_KS | holding one ciphertext byte, waiting for its keystream byte

module trivium_stream_decrypt #(
  parameter int DEPTH         = 8,
  parameter int DISCARD_BYTES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     resync,
  input  logic [7:0]               ct_data,
  input  logic                     ct_valid,
  output logic                     ct_ready,
  input  logic [7:0]               ks_byte,
  input  logic                     ks_valid,
  output logic                     ks_ready,
  output logic [7:0]               pt_data,
  output logic                     pt_valid,
  input  logic                     pt_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_DISCARD = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WAIT_KS = 2'd2
  } state_t;

  // With nothing to discard the block comes out of reset ready for ciphertext.
  localparam state_t          ST_START     = (DISCARD_BYTES > 0) ? ST_DISCARD : ST_IDLE;
  localparam logic [15:0]     DISCARD_INIT = 16'(DISCARD_BYTES);
  localparam logic [LW-1:0]   LEVEL_FULL   = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trivium_stream_decrypt: DEPTH must be a power of 2 and at least 2");
  end

  if (DISCARD_BYTES < 0 || DISCARD_BYTES > 65535) begin : g_bad_discard
    $error("trivium_stream_decrypt: DISCARD_BYTES must be within 0..65535");
  end

  state_t          state;
  logic [15:0]     disc_cnt;
  logic [7:0]      ct_hold;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ct_hs;
  logic            ks_hs;
  logic            fifo_wr;
  logic            fifo_rd;
  logic            disc_tc;

  assign flush      = rst | resync;
  assign fifo_full  = (level == LEVEL_FULL);
  assign fifo_empty = (level == '0);

  // Readies depend only on registered state and FIFO flags, never on valids.
  // Ciphertext is only taken when a FIFO slot is free; no pop can fill the
  // FIFO while a byte is held, so the later write always has room.
  assign ct_ready = (state == ST_IDLE) && !fifo_full;
  assign ks_ready = (state == ST_DISCARD) || (state == ST_WAIT_KS);

  assign ct_hs    = ct_valid && ct_ready;
  assign ks_hs    = ks_valid && ks_ready;
  assign disc_tc  = (disc_cnt == 16'd1);

  assign fifo_wr  = ks_hs && (state == ST_WAIT_KS);
  assign fifo_rd  = pt_ready && !fifo_empty;

  assign pt_valid   = !fifo_empty;
  assign pt_data    = mem[rd_ptr];
  assign fifo_level = level;

  // Sequencer: discard countdown, ciphertext capture, keystream pairing.
  always_ff @(posedge clk) begin
    if (flush) begin
      state    <= ST_START;
      disc_cnt <= DISCARD_INIT;
      ct_hold  <= '0;
    end else begin
      case (state)
        ST_DISCARD: begin
          if (ks_hs) begin
            disc_cnt <= disc_cnt - 16'd1;
            if (disc_tc) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (ct_hs) begin
            ct_hold <= ct_data;
            state   <= ST_WAIT_KS;
          end
        end
        ST_WAIT_KS: begin
          if (ks_hs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_START;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the plaintext byte counter.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      byte_count <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr     <= wr_ptr + AW'(1);
        byte_count <= byte_count + 16'd1;
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; stale contents after a flush are never visible.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= ct_hold ^ ks_byte;
    end
  end

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// Bench for trivium_stream_decrypt: transaction-level model plus directed
// vectors with hand-computed plaintext.

module tb_trivium_stream_decrypt;

  localparam int DEPTH_A = 8;
  localparam int DEPTH_D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: no discard, depth 8
  logic        rst_a, resync_a, ct_valid_a, ks_valid_a, pt_ready_a;
  logic [7:0]  ct_data_a, ks_byte_a;
  logic        ct_ready_a, ks_ready_a, pt_valid_a;
  logic [7:0]  pt_data_a;
  logic [3:0]  fifo_level_a;
  logic [15:0] byte_count_a;

  // Instance D: three-byte discard, depth 4
  logic        rst_d, resync_d, ct_valid_d, ks_valid_d, pt_ready_d;
  logic [7:0]  ct_data_d, ks_byte_d;
  logic        ct_ready_d, ks_ready_d, pt_valid_d;
  logic [7:0]  pt_data_d;
  logic [2:0]  fifo_level_d;
  logic [15:0] byte_count_d;

  trivium_stream_decrypt #(.DEPTH(DEPTH_A), .DISCARD_BYTES(0)) dut_a (
    .clk(clk), .rst(rst_a), .resync(resync_a),
    .ct_data(ct_data_a), .ct_valid(ct_valid_a), .ct_ready(ct_ready_a),
    .ks_byte(ks_byte_a), .ks_valid(ks_valid_a), .ks_ready(ks_ready_a),
    .pt_data(pt_data_a), .pt_valid(pt_valid_a), .pt_ready(pt_ready_a),
    .fifo_level(fifo_level_a), .byte_count(byte_count_a)
  );

  trivium_stream_decrypt #(.DEPTH(DEPTH_D), .DISCARD_BYTES(3)) dut_d (
    .clk(clk), .rst(rst_d), .resync(resync_d),
    .ct_data(ct_data_d), .ct_valid(ct_valid_d), .ct_ready(ct_ready_d),
    .ks_byte(ks_byte_d), .ks_valid(ks_valid_d), .ks_ready(ks_ready_d),
    .pt_data(pt_data_d), .pt_valid(pt_valid_d), .pt_ready(pt_ready_d),
    .fifo_level(fifo_level_d), .byte_count(byte_count_d)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of instance A: a plaintext queue, one held ciphertext byte, a count.
  logic [7:0]  mq[$];
  bit          m_hold      = 1'b0;
  logic [7:0]  m_hold_byte = '0;
  logic [15:0] m_cnt       = '0;
  bit          m_ct_hs     = 1'b0;

  always @(posedge clk) begin
    bit may_take_ct;
    bit may_take_ks;
    may_take_ct = !m_hold && (mq.size() < DEPTH_A);
    may_take_ks = m_hold;
    m_ct_hs = 1'b0;
    if (rst_a || resync_a) begin
      mq.delete();
      m_hold = 1'b0;
      m_cnt  = '0;
    end else begin
      if (pt_ready_a && mq.size() != 0) void'(mq.pop_front());
      if (may_take_ks && ks_valid_a) begin
        mq.push_back(m_hold_byte ^ ks_byte_a);
        m_cnt  = m_cnt + 16'd1;
        m_hold = 1'b0;
      end
      if (may_take_ct && ct_valid_a) begin
        m_hold_byte = ct_data_a;
        m_hold      = 1'b1;
        m_ct_hs     = 1'b1;
      end
    end
  end

  // Port-level observation: keystream pops and plaintext reads.
  int         ks_hs_a = 0;
  int         ks_hs_d = 0;
  int         rd_cnt  = 0;
  logic [7:0] rdbuf [512];

  always @(posedge clk) begin
    if (ks_valid_a && ks_ready_a) ks_hs_a++;
    if (ks_valid_d && ks_ready_d) ks_hs_d++;
    if (pt_valid_a && pt_ready_a && rd_cnt < 512) begin
      rdbuf[rd_cnt] = pt_data_a;
      rd_cnt++;
    end
  end

  task automatic push_bytes(input int n, input logic [7:0] first, input logic [7:0] ks);
    int sent = 0;
    int budget = 0;
    ks_byte_a  = ks;
    ks_valid_a = 1'b1;
    while (sent < n && budget < 200) begin
      ct_data_a  = first + sent[7:0];
      ct_valid_a = 1'b1;
      tick();
      if (m_ct_hs) sent++;
      budget++;
    end
    ct_valid_a = 1'b0;
    tick();
    ks_valid_a = 1'b0;
    chk("push_accepted", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    int b = 0;
    pt_ready_a = 1'b1;
    while (pt_valid_a && b < 40) begin
      tick();
      b++;
    end
    pt_ready_a = 1'b0;
    chk("drain_empty", 32'(pt_valid_a), 32'(0));
  endtask

  initial begin
    int base;
    rst_a = 1'b1; resync_a = 1'b0; ct_valid_a = 1'b0; ks_valid_a = 1'b0; pt_ready_a = 1'b0;
    ct_data_a = '0; ks_byte_a = '0;
    rst_d = 1'b1; resync_d = 1'b0; ct_valid_d = 1'b0; ks_valid_d = 1'b0; pt_ready_d = 1'b0;
    ct_data_d = '0; ks_byte_d = '0;

    fork
      begin
        forever begin
          @(negedge clk);
          if (chk_en) begin
            chk("m_ct_ready", 32'(ct_ready_a), 32'(!m_hold && (mq.size() < DEPTH_A)));
            chk("m_ks_ready", 32'(ks_ready_a), 32'(m_hold));
            chk("m_pt_valid", 32'(pt_valid_a), 32'(mq.size() != 0));
            chk("m_level", 32'(fifo_level_a), 32'(mq.size()));
            chk("m_count", 32'(byte_count_a), 32'(m_cnt));
            if (mq.size() != 0) chk("m_pt_data", 32'(pt_data_a), 32'(mq[0]));
          end
        end
      end
    join_none

    tick();
    tick();
    rst_a = 1'b0;
    rst_d = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst_pt_valid", 32'(pt_valid_a), 32'(0));
    chk("rst_level", 32'(fifo_level_a), 32'(0));
    chk("rst_count", 32'(byte_count_a), 32'(0));
    chk("rst_ct_ready", 32'(ct_ready_a), 32'(1));
    chk("rst_ks_ready", 32'(ks_ready_a), 32'(0));
    chk("rst_d_ct_ready", 32'(ct_ready_d), 32'(0));
    chk("rst_d_ks_ready", 32'(ks_ready_d), 32'(1));

    // 1: basic decrypt A5 ^ 3C = 99
    base = ks_hs_a;
    ct_data_a = 8'hA5; ct_valid_a = 1'b1;
    tick();
    ct_valid_a = 1'b0;
    chk("t1_ct_ready_held", 32'(ct_ready_a), 32'(0));
    chk("t1_pt_valid_early", 32'(pt_valid_a), 32'(0));
    ks_byte_a = 8'h3C; ks_valid_a = 1'b1;
    tick();
    ks_valid_a = 1'b0;
    chk("t1_pt_valid", 32'(pt_valid_a), 32'(1));
    chk("t1_pt_data", 32'(pt_data_a), 32'h99);
    chk("t1_count", 32'(byte_count_a), 32'(1));
    chk("t1_ks_pops", 32'(ks_hs_a - base), 32'(1));
    drain();

    // 2: discard on instance D, including a resync partway through the discard
    ks_byte_d = 8'hEE; ks_valid_d = 1'b1;
    tick();
    ks_valid_d = 1'b0;
    resync_d = 1'b1;
    tick();
    resync_d = 1'b0;
    chk("t2_ct_ready_after_resync", 32'(ct_ready_d), 32'(0));
    ct_data_d = 8'h44; ct_valid_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ks_byte_d = 8'(i + 1);
      ks_valid_d = 1'b1;
      chk("t2_disc_ct_ready", 32'(ct_ready_d), 32'(0));
      chk("t2_disc_ks_ready", 32'(ks_ready_d), 32'(1));
      tick();
    end
    chk("t2_ct_ready", 32'(ct_ready_d), 32'(1));
    chk("t2_ks_ready", 32'(ks_ready_d), 32'(0));
    chk("t2_no_discard_write", 32'(fifo_level_d), 32'(0));
    ks_byte_d = 8'h44;
    tick();
    ct_valid_d = 1'b0;
    chk("t2_wait_ks_ready", 32'(ks_ready_d), 32'(1));
    chk("t2_pt_valid_early", 32'(pt_valid_d), 32'(0));
    tick();
    ks_valid_d = 1'b0;
    chk("t2_pt_valid", 32'(pt_valid_d), 32'(1));
    chk("t2_pt_data", 32'(pt_data_d), 32'h00);
    chk("t2_count", 32'(byte_count_d), 32'(1));
    chk("t2_level", 32'(fifo_level_d), 32'(1));
    chk("t2_ks_pops", 32'(ks_hs_d), 32'(5));

    // 3: backpressure to full, then one pop admits one more byte
    pt_ready_a = 1'b0;
    push_bytes(8, 8'h30, 8'h5A);
    chk("t3_level_full", 32'(fifo_level_a), 32'(8));
    ct_data_a = 8'h38; ct_valid_a = 1'b1;
    ks_byte_a = 8'h5A; ks_valid_a = 1'b1;
    repeat (4) begin
      tick();
      chk("t3_full_ct_ready", 32'(ct_ready_a), 32'(0));
      chk("t3_full_level", 32'(fifo_level_a), 32'(8));
    end
    chk("t3_head", 32'(pt_data_a), 32'(8'h30 ^ 8'h5A));
    pt_ready_a = 1'b1;
    tick();
    pt_ready_a = 1'b0;
    chk("t3_level_after_pop", 32'(fifo_level_a), 32'(7));
    chk("t3_ct_ready_after_pop", 32'(ct_ready_a), 32'(1));
    tick();
    ct_valid_a = 1'b0;
    chk("t3_byte9_taken", 32'(ks_ready_a), 32'(1));
    tick();
    ks_valid_a = 1'b0;
    chk("t3_level_refill", 32'(fifo_level_a), 32'(8));
    drain();

    // 4: simultaneous write and pop at level 7, order across pointer wrap
    base = rd_cnt;
    push_bytes(7, 8'h00, 8'h00);
    chk("t4_level7", 32'(fifo_level_a), 32'(7));
    ct_data_a = 8'h07; ct_valid_a = 1'b1;
    tick();
    ct_valid_a = 1'b0;
    ks_byte_a = 8'h00; ks_valid_a = 1'b1; pt_ready_a = 1'b1;
    tick();
    ks_valid_a = 1'b0; pt_ready_a = 1'b0;
    chk("t4_simul_level", 32'(fifo_level_a), 32'(7));
    pt_ready_a = 1'b1;
    push_bytes(12, 8'h08, 8'h00);
    drain();
    chk("t4_read_count", 32'(rd_cnt - base), 32'(20));
    for (int i = 0; i < 20; i++) begin
      chk("t4_read_order", 32'(rdbuf[base + i]), 32'(i));
    end

    // 5: keystream stall, 10 ^ 01 = 11
    ct_data_a = 8'h10; ct_valid_a = 1'b1;
    tick();
    ct_valid_a = 1'b0; ks_valid_a = 1'b0;
    repeat (50) begin
      chk("t5_stall_ks_ready", 32'(ks_ready_a), 32'(1));
      chk("t5_stall_ct_ready", 32'(ct_ready_a), 32'(0));
      tick();
    end
    ks_byte_a = 8'h01; ks_valid_a = 1'b1;
    tick();
    ks_valid_a = 1'b0;
    chk("t5_pt_valid", 32'(pt_valid_a), 32'(1));
    chk("t5_pt_data", 32'(pt_data_a), 32'h11);
    drain();

    // 6: resync while holding a byte with three bytes queued
    push_bytes(3, 8'h60, 8'h0F);
    ct_data_a = 8'h77; ct_valid_a = 1'b1;
    tick();
    ct_valid_a = 1'b0;
    chk("t6_holding", 32'(ks_ready_a), 32'(1));
    chk("t6_level3", 32'(fifo_level_a), 32'(3));
    resync_a = 1'b1;
    tick();
    resync_a = 1'b0;
    chk("t6_pt_valid", 32'(pt_valid_a), 32'(0));
    chk("t6_level", 32'(fifo_level_a), 32'(0));
    chk("t6_count", 32'(byte_count_a), 32'(0));
    chk("t6_ks_ready", 32'(ks_ready_a), 32'(0));
    chk("t6_ct_ready", 32'(ct_ready_a), 32'(1));
    base = ks_hs_a;
    ks_byte_a = 8'hAA; ks_valid_a = 1'b1;
    repeat (3) tick();
    ks_valid_a = 1'b0;
    chk("t6_no_ks_pop", 32'(ks_hs_a - base), 32'(0));

    // reset mid-stream
    push_bytes(2, 8'h90, 8'h0F);
    ct_data_a = 8'h55; ct_valid_a = 1'b1;
    tick();
    ct_valid_a = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("rst2_pt_valid", 32'(pt_valid_a), 32'(0));
    chk("rst2_level", 32'(fifo_level_a), 32'(0));
    chk("rst2_count", 32'(byte_count_a), 32'(0));
    chk("rst2_ks_ready", 32'(ks_ready_a), 32'(0));
    chk("rst2_ct_ready", 32'(ct_ready_a), 32'(1));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trivium_stream_decrypt.md
Name: trivium_stream_decrypt

Overview:
Receive-side counterpart of the Trivium encrypt path. Accepts ciphertext bytes, normally from the UART receiver. Pulls one keystream byte per ciphertext byte from a Trivium keystream source over a valid/ready pop handshake. XORs the two bytes and buffers the recovered plaintext in an internal FIFO, which the UART transmitter or host logic drains with valid/ready. A resync input realigns the keystream position with the far-end encryptor.

Parameters:
DEPTH, 8, plaintext FIFO entries; power of 2, minimum 2.
DISCARD_BYTES, 0, keystream bytes popped and dropped after reset/resync before the first decrypt; 0 to 65535.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
resync  input  1  synchronous flush and realign; single-cycle pulse or held.
ct_data  input  8  ciphertext byte.
ct_valid  input  1  ct_data valid.
ct_ready  output  1  block accepts ct_data this cycle.
ks_byte  input  8  keystream byte from Trivium.
ks_valid  input  1  ks_byte valid.
ks_ready  output  1  pop strobe to keystream source; a byte is consumed when ks_valid && ks_ready.
pt_data  output  8  plaintext byte at FIFO head (show-ahead).
pt_valid  output  1  FIFO not empty.
pt_ready  input  1  consumer pops head when pt_valid && pt_ready.
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
byte_count  output  16  plaintext bytes written since last reset/resync; wraps 0xFFFF->0x0000.

Behaviour:
- Interface: single clock, synchronous active-high reset `rst`.
- Reset (rst=1 at an edge):
  - FIFO emptied; pt_valid=0; fifo_level=0; byte_count=0; held ct byte cleared; discard counter = DISCARD_BYTES.
  - State = DISCARD if DISCARD_BYTES>0, else IDLE.
- Priority: rst > resync > normal operation. resync performs the same actions as rst except it does not affect ks source state (external).
- States:
  - DISCARD: ks_ready=1, ct_ready=0. Each ks handshake decrements the counter. On the handshake that takes the counter 1->0, go to IDLE.
  - IDLE: ct_ready = !fifo_full, ks_ready=0. On ct handshake, latch ct_data into ct_hold and go to WAIT_KS.
  - WAIT_KS: ct_ready=0, ks_ready=1. On ks handshake, write (ct_hold XOR ks_byte) into the FIFO at that edge, increment byte_count, and go to IDLE. Stalls indefinitely while ks_valid=0.
- ct_ready and ks_ready are combinational from registered state and FIFO flags only; they never depend on ct_valid/ks_valid.
- Latency: ct accepted at edge N; ks_valid high during N..N+1 gives pt_valid high after edge N+1. Best-case throughput is 1 byte per 2 cycles.
- FIFO:
  - Circular buffer, write/read pointers wrap at DEPTH.
  - Full when level==DEPTH; ct_ready=0 when full. A ct byte is only accepted when a slot is guaranteed, so no write is ever dropped.
  - A simultaneous pop and write in the same cycle leaves the level unchanged, including when level==DEPTH-1 or level==1.
  - A pop on an empty FIFO is ignored.
  - pt_data is undefined when pt_valid=0.
- A pt_ready stall never stalls the ks pop for an already-held ct byte. Full only blocks new ct acceptance.
- resync mid-WAIT_KS drops ct_hold without consuming keystream. resync mid-DISCARD restarts the count at DISCARD_BYTES.
- byte_count increments only on FIFO writes, never on discards.

Test Plan:
1. Basic decrypt, DISCARD_BYTES=0: ct=0xA5, ks=0x3C valid one cycle after accept. Require pt_data=0x99 with pt_valid rising after edge N+1, byte_count=1, and exactly one ks handshake.
2. Discard, DISCARD_BYTES=3: ks stream 0x01,0x02,0x03,0x44; then ct=0x44. Require ct_ready=0 until three ks pops complete, then pt_data=0x00. The first three ks bytes never reach the FIFO.
3. Backpressure, DEPTH=8: hold pt_ready=0 and send 10 ct bytes with ks always valid. Require fifo_level=8 and ct_ready=0 after the 8th write, and bytes 9-10 not accepted. Then one pop: level 7, ct_ready=1, byte 9 accepted.
4. Simultaneous push/pop at level 7: pop and write in the same cycle. Require level stays 7 and data order is preserved across pointer wrap (write 20 bytes 0x00..0x13 with ks=0x00; read back identical in order).
5. Keystream stall: ct=0x10 accepted, ks_valid=0 for 50 cycles, then ks=0x01. Require ks_ready=1 throughout the stall, ct_ready=0 throughout, and pt_data=0x11 once ks arrives.
6. Resync mid-WAIT_KS with 3 bytes in the FIFO: pulse resync. Require next cycle pt_valid=0, fifo_level=0, byte_count=0, and no ks handshake for the dropped byte. Reset: rst=1 mid-stream gives the same cleared outputs.
